// File: rtl/pc_fetch_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pc_fetch_ctrl_pkg                                            |
// | Description : Shared CPU constants for the fetch stage: FSM state          |
// |               encoding, reset PC and the sequential PC increment.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pc_fetch_ctrl_pkg;

  // Fetch controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  // PC loaded on reset
  localparam int unsigned c_pc_reset = 0;

  // Sequential PC step (one 32-bit instruction)
  localparam int unsigned c_pc_incr  = 4;

endpackage : pc_fetch_ctrl_pkg
`default_nettype wire

// File: rtl/pc_next_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pc_next_mux                                                  |
// | Description : Combinational next-PC selection for the fetch stage.         |
// |               Priority: branch > jr > jump > pc+4. A stall holds the PC    |
// |               unless a branch is present. Flags whether a redirect was     |
// |               accepted and whether the accepted target is misaligned.      |
// | Ports       : i_pc / i_pc_4        current PC and PC+4                     |
// |               i_stall              hazard freeze                           |
// |               i_branch/jr/jump     redirect requests with target addresses |
// |               o_next_pc            PC for the next cycle (PC held on error)|
// |               o_redirect           a redirect was accepted                 |
// |               o_misaligned         accepted target has bits [1:0] != 0     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pc_next_mux #(
  parameter int NB_DATA = 32
) (
  input  logic [NB_DATA-1:0] i_pc,
  input  logic [NB_DATA-1:0] i_pc_4,
  input  logic               i_stall,
  input  logic               i_branch,
  input  logic [NB_DATA-1:0] i_branch_address,
  input  logic               i_jr,
  input  logic [NB_DATA-1:0] i_jr_address,
  input  logic               i_jump,
  input  logic [NB_DATA-1:0] i_jump_address,
  output logic [NB_DATA-1:0] o_next_pc,
  output logic               o_redirect,
  output logic               o_misaligned
);

  logic [NB_DATA-1:0] w_target;

  always_comb begin
    w_target   = i_pc_4;
    o_redirect = 1'b0;
    if (i_branch) begin
      // A branch overrides a stall
      w_target   = i_branch_address;
      o_redirect = 1'b1;
    end else if (i_stall) begin
      w_target   = i_pc;
    end else if (i_jr) begin
      w_target   = i_jr_address;
      o_redirect = 1'b1;
    end else if (i_jump) begin
      w_target   = i_jump_address;
      o_redirect = 1'b1;
    end
  end

  assign o_misaligned = o_redirect && (w_target[1:0] != 2'b00);

  // A misaligned target never reaches the PC register
  assign o_next_pc = o_misaligned ? i_pc : w_target;

endmodule : pc_next_mux
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pc_fetch_ctrl                                                |
// | Description : PC register and IDLE/RUN/HALTED fetch FSM. Selects the next  |
// |               PC through pc_next_mux, raises flush on redirects, records a |
// |               sticky misaligned-target error and counts RUN cycles.        |
// | Ports       : clock_i, reset_i (sync, active-high)                         |
// |               start_i, stall_i, halt_i                  control requests   |
// |               branch_i/jr_i/jump_i + *_address_i        redirects          |
// |               pc_o, pc_4_o, pc_4_upper_o                fetch address      |
// |               flush_o, fetch_valid_o, halted_o          status             |
// |               addr_err_o, cycle_count_o                 error / counter    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int                 NB_DATA  = 32,
  parameter int                 NB_JUMP  = 26,
  parameter logic [NB_DATA-1:0] PC_RESET = NB_DATA'(c_pc_reset)
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic                       stall_i,
  input  logic                       branch_i,
  input  logic [NB_DATA-1:0]         branch_address_i,
  input  logic                       jr_i,
  input  logic [NB_DATA-1:0]         jr_address_i,
  input  logic                       jump_i,
  input  logic [NB_DATA-1:0]         jump_address_i,
  input  logic                       halt_i,
  output logic [NB_DATA-1:0]         pc_o,
  output logic [NB_DATA-1:0]         pc_4_o,
  output logic [NB_DATA-NB_JUMP-3:0] pc_4_upper_o,
  output logic                       flush_o,
  output logic                       fetch_valid_o,
  output logic                       halted_o,
  output logic                       addr_err_o,
  output logic [NB_DATA-1:0]         cycle_count_o
);

  localparam logic [NB_DATA-1:0] c_incr = NB_DATA'(c_pc_incr);
  localparam logic [NB_DATA-1:0] c_one  = NB_DATA'(1);

  fetch_state_e       r_state;
  fetch_state_e       w_state_next;
  logic [NB_DATA-1:0] r_pc;
  logic [NB_DATA-1:0] w_pc_next;
  logic [NB_DATA-1:0] w_pc_4;
  logic [NB_DATA-1:0] r_cycle_count;
  logic               r_addr_err;
  logic               w_err_set;
  logic               w_flush;
  logic               w_fetch_valid;
  logic [NB_DATA-1:0] w_mux_pc;
  logic               w_mux_redirect;
  logic               w_mux_misaligned;

  assign w_pc_4 = r_pc + c_incr;

  pc_next_mux #(
    .NB_DATA (NB_DATA)
  ) u_pc_next_mux (
    .i_pc             (r_pc),
    .i_pc_4           (w_pc_4),
    .i_stall          (stall_i),
    .i_branch         (branch_i),
    .i_branch_address (branch_address_i),
    .i_jr             (jr_i),
    .i_jr_address     (jr_address_i),
    .i_jump           (jump_i),
    .i_jump_address   (jump_address_i),
    .o_next_pc        (w_mux_pc),
    .o_redirect       (w_mux_redirect),
    .o_misaligned     (w_mux_misaligned)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state       <= ST_IDLE;
      r_pc          <= PC_RESET;
      r_addr_err    <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_addr_err <= r_addr_err | w_err_set;
      if (r_state == ST_RUN) begin
        r_cycle_count <= r_cycle_count + c_one;
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_err_set     = 1'b0;
    w_flush       = 1'b0;
    w_fetch_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_pc_next     = w_mux_pc;
        w_flush       = w_mux_redirect;
        w_err_set     = w_mux_misaligned;
        w_fetch_valid = !stall_i || branch_i;
        // Halt freezes the PC, but a same-cycle redirect still lands first
        if (halt_i && !w_mux_redirect) begin
          w_pc_next = r_pc;
        end
        if (halt_i || w_mux_misaligned) begin
          w_state_next = ST_HALTED;
        end
      end
      ST_HALTED: begin
        w_state_next = ST_HALTED;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign pc_o          = r_pc;
  assign pc_4_o        = w_pc_4;
  assign pc_4_upper_o  = w_pc_4[NB_DATA-1 -: (NB_DATA-NB_JUMP-2)];
  assign addr_err_o    = r_addr_err;
  assign cycle_count_o = r_cycle_count;

  // Status outputs are forced low while reset is asserted
  assign flush_o       = w_flush && !reset_i;
  assign fetch_valid_o = w_fetch_valid && !reset_i;
  assign halted_o      = (r_state == ST_HALTED) && !reset_i;

endmodule : pc_fetch_ctrl
`default_nettype wire

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter NB_DATA, default 32, SHALL set the width of every PC and target-address port.
REQ-002 Parameter NB_JUMP, default 26, SHALL set the width of the jump-field convention; upper-nibble width is NB_DATA-NB_JUMP-2, which is 4 bits.
REQ-003 Parameter PC_RESET, default 0, SHALL set the PC value loaded on reset.
REQ-004 Port clock_i, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset_i, input, 1 bit, SHALL be the reset; it is synchronous and active-high.
REQ-006 Port start_i, input, 1 bit, SHALL be the IDLE-to-RUN request.
REQ-007 Port stall_i, input, 1 bit, SHALL be the hazard-unit freeze request.
REQ-008 Port branch_i / branch_address_i, input, 1 / NB_DATA bits, SHALL be the taken-branch redirect from the later stage.
REQ-009 Port jr_i / jr_address_i, input, 1 / NB_DATA bits, SHALL be the register-jump redirect.
REQ-010 Port jump_i / jump_address_i, input, 1 / NB_DATA bits, SHALL be the J/JAL redirect, carrying the address assembled by the jump-address unit.
REQ-011 Port halt_i, input, 1 bit, SHALL flag that the instruction currently being decoded is HALT.
REQ-012 Port pc_o, output, NB_DATA bits, SHALL be the current fetch address.
REQ-013 Port pc_4_o, output, NB_DATA bits, SHALL equal pc_o+4.
REQ-014 Port pc_4_upper_o, output, 4 bits, SHALL equal pc_4_o[NB_DATA-1:NB_DATA-4], fed back to the jump-address unit.
REQ-015 Port flush_o, output, 1 bit, SHALL instruct IF/ID to discard the fetched instruction.
REQ-016 Port fetch_valid_o, output, 1 bit, SHALL mark that pc_o is a live fetch.
REQ-017 Port halted_o, output, 1 bit, SHALL be high while the FSM is in HALTED.
REQ-018 Port addr_err_o, output, 1 bit, SHALL be a sticky misaligned-target error flag.
REQ-019 Port cycle_count_o, output, NB_DATA bits, SHALL count cycles spent in RUN.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, RUN and HALTED.
REQ-021 IDLE SHALL move to RUN on start_i; RUN SHALL move to HALTED on halt_i or on a misaligned accepted target; HALTED SHALL be left only by reset.
REQ-022 In RUN, the next PC SHALL be chosen by priority: branch_i, then jr_i, then jump_i, then pc+4; lower-priority requests in the same cycle are ignored.
REQ-023 stall_i SHALL hold the PC for a cycle unless branch_i is set, because a branch overrides a stall.
REQ-024 Redirect latency: a redirect accepted in cycle N SHALL appear on pc_o in cycle N+1.
REQ-025 flush_o SHALL be combinational and high in any RUN cycle where a redirect is accepted; it SHALL be low otherwise.
REQ-026 Sequential increments SHALL wrap modulo 2^NB_DATA, so 0xFFFFFFFC is followed by 0x00000000.
REQ-027 An accepted target with bits [1:0] not equal to 0 SHALL leave the PC unchanged, set addr_err_o and move the FSM to HALTED.
REQ-028 halt_i SHALL freeze the PC at its current value; if halt_i and a redirect arrive in the same cycle, the redirect SHALL be applied first and HALTED entered in the same cycle.
REQ-029 fetch_valid_o SHALL be 1 only in RUN with stall_i=0 or branch_i=1.
REQ-030 cycle_count_o SHALL increment in every RUN cycle, stalls included, and SHALL wrap silently.
REQ-031 In IDLE and HALTED, every request input SHALL be ignored.

Reset
REQ-032 When reset_i=1 at a clock edge, the block SHALL set pc_o=PC_RESET, state=IDLE, addr_err_o=0 and cycle_count_o=0.
REQ-033 During reset, flush_o, fetch_valid_o and halted_o SHALL be 0.
REQ-034 Reset SHALL take priority over every other input, including mid-redirect and mid-stall.

Structure
REQ-035 The FSM state encoding and PC_RESET SHALL live in the shared CPU package, together with the constant 4 used as the PC increment.
REQ-036 The design SHALL contain one sub-module, pc_next_mux, holding the combinational priority and alignment check; the FSM and registers SHALL stay in the top level.

Verification
REQ-037 Sequential run: reset, then start_i, then 4 free cycles -> pc_o 0,4,8,C,10; cycle_count_o=4.
REQ-038 Jump: at pc=0x8, jump_i=1 with jump_address_i=0x00000040 -> flush_o=1 that cycle, pc_o=0x40 next cycle, pc_4_upper_o=0x0.
REQ-039 Simultaneous requests: branch_i=1 (0x100), jr_i=1 (0x200), jump_i=1 (0x300) and stall_i=1 in one cycle -> pc_o=0x100 next cycle.
REQ-040 Misaligned jr: jr_address_i=0x0000_0022 -> pc_o unchanged, addr_err_o=1, halted_o=1; later branch_i has no effect until reset.
REQ-041 Wrap: pc=0xFFFFFFFC, no request -> pc_o=0x00000000.
REQ-042 Reset mid-stall: stall_i=1 in RUN, reset_i=1 -> next cycle pc_o=PC_RESET and state IDLE, with start_i required to resume.
